// File: rtl/mem_arbiter_if.sv
// Signal bundle for the fetch/data to shared-bus arbiter.
// master: arbiter view; slave: CPU and memory environment view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_done;
    logic              i_stall;

    logic              d_req;
    logic              d_wr;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic [DW-1:0]     d_rdata;
    logic              d_done;
    logic              d_stall;

    logic              bus_req;
    logic              bus_wr;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW/8-1:0]   bus_wstrb;
    logic              bus_ack;
    logic [DW-1:0]     bus_rdata;
    logic              bus_err;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_wr, d_addr, d_wdata, d_wstrb,
        input  bus_ack, bus_rdata,
        output i_rdata, i_done, i_stall,
        output d_rdata, d_done, d_stall,
        output bus_req, bus_wr, bus_addr,
        output bus_wdata, bus_wstrb, bus_err
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_wr, d_addr, d_wdata, d_wstrb,
        output bus_ack, bus_rdata,
        input  i_rdata, i_done, i_stall,
        input  d_rdata, d_done, d_stall,
        input  bus_req, bus_wr, bus_addr,
        input  bus_wdata, bus_wstrb, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory bus.
// One transaction at a time: IDLE -> BUS -> RESP, with a bus timeout.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master mem
);
    localparam int          SW  = DW / 8;
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic          lastD;
    logic          ownD;
    logic          errQ;
    logic [15:0]   cycleCnt;
    logic [15:0]   cntInc;

    logic          anyReq;
    logic          pickD;
    logic          grantNow;
    logic          inBus;
    logic          ackHit;
    logic          timeoutHit;

    logic          busReq;
    logic          iDone;
    logic          dDone;

    logic          busWrQ;
    logic [AW-1:0] busAddrQ;
    logic [DW-1:0] busWdataQ;
    logic [SW-1:0] busWstrbQ;
    logic [DW-1:0] iRdataQ;
    logic [DW-1:0] dRdataQ;

    // A lone requester always wins; on contention the grant alternates.
    always_comb begin
        anyReq     = mem.i_req | mem.d_req;
        pickD      = mem.d_req & (~mem.i_req | ~lastD);
        inBus      = (state == BUS);
        grantNow   = (state == IDLE) & anyReq;
        ackHit     = inBus & mem.bus_ack;
        cntInc     = cycleCnt + 16'd1;
        timeoutHit = inBus & ~mem.bus_ack
                   & (cntInc == TMO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = BUS;
                end
            end
            BUS: begin
                if (ackHit | timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        busReq = 1'b0;
        iDone  = 1'b0;
        dDone  = 1'b0;
        unique case (state)
            IDLE: ;
            BUS: begin
                busReq = 1'b1;
            end
            RESP: begin
                iDone = ~ownD;
                dDone = ownD;
            end
            default: ;
        endcase
    end

    // Bus fields are latched once at grant and held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastD     <= 1'b0;
            ownD      <= 1'b0;
            busWrQ    <= 1'b0;
            busAddrQ  <= '0;
            busWdataQ <= '0;
            busWstrbQ <= '0;
        end else if (grantNow) begin
            lastD     <= pickD;
            ownD      <= pickD;
            busWrQ    <= pickD & mem.d_wr;
            busAddrQ  <= pickD ? mem.d_addr : mem.i_addr;
            busWdataQ <= pickD ? mem.d_wdata : '0;
            busWstrbQ <= pickD ? mem.d_wstrb : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCnt <= '0;
            errQ     <= 1'b0;
            iRdataQ  <= '0;
            dRdataQ  <= '0;
        end else if (grantNow) begin
            cycleCnt <= '0;
        end else if (ackHit) begin
            if (ownD) begin
                dRdataQ <= mem.bus_rdata;
            end else begin
                iRdataQ <= mem.bus_rdata;
            end
        end else if (timeoutHit) begin
            errQ <= 1'b1;
            if (ownD) begin
                dRdataQ <= '0;
            end else begin
                iRdataQ <= '0;
            end
        end else if (inBus) begin
            cycleCnt <= cntInc;
        end
    end

    assign mem.bus_req   = busReq;
    assign mem.bus_wr    = busWrQ;
    assign mem.bus_addr  = busAddrQ;
    assign mem.bus_wdata = busWdataQ;
    assign mem.bus_wstrb = busWstrbQ;
    assign mem.bus_err   = errQ;

    assign mem.i_done    = iDone;
    assign mem.d_done    = dDone;
    assign mem.i_rdata   = iRdataQ;
    assign mem.d_rdata   = dRdataQ;
    assign mem.i_stall   = mem.i_req & ~iDone;
    assign mem.d_stall   = mem.d_req & ~dDone;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take the following parameters, one per line as name, default, meaning:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum BUS-state cycles allowed without bus_ack
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-fetch read request, held until i_done
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch read data, valid with i_done
- i_done  out  1  one-cycle fetch completion pulse
- i_stall  out  1  fetch stall to hazard logic
- d_req  in  1  data request, held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_wstrb  in  DW/8  byte write strobes
- d_rdata  out  DW  data read data, valid with d_done
- d_done  out  1  one-cycle data completion pulse
- d_stall  out  1  memory-stage stall to hazard logic
- bus_req  out  1  shared-bus transaction valid
- bus_wr, bus_addr, bus_wdata, bus_wstrb  out  1/AW/DW/DW/8  registered transaction fields
- bus_ack  in  1  bus completion; bus_rdata valid this cycle
- bus_rdata  in  DW  bus read data
- bus_err  out  1  sticky timeout flag

Function
REQ-003 The FSM SHALL have states IDLE, BUS and RESP.
REQ-004 In IDLE with any request pending, the block SHALL grant one requester, register its fields onto bus_*, and enter BUS on the next edge.
- For instruction grants, bus_wr SHALL be 0 and bus_wstrb SHALL be 0.
REQ-005 Arbitration when both requests are pending SHALL strictly alternate, tracked by a last_d flag:
- data wins if last_d=0;
- instruction wins if last_d=1.
REQ-006 When a single request is pending, it SHALL win regardless of last_d.
REQ-007 last_d SHALL update on every grant: 1 for a data grant, 0 for an instruction grant.
REQ-008 In BUS, bus_req SHALL be 1, and bus_* fields SHALL stay constant until exit.
REQ-009 bus_ack in BUS SHALL capture bus_rdata into the granted requester's rdata register and move to RESP.
REQ-010 A 16-bit cycle counter SHALL clear on BUS entry and increment each BUS cycle without ack.
- On reaching TIMEOUT, the block SHALL enter RESP, load rdata with 0 and set bus_err.
- bus_err SHALL clear only on reset.
REQ-011 In RESP, the granted requester's done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
- bus_req SHALL be 0 in RESP and IDLE.
REQ-012 Minimum latency SHALL be 3 cycles: request seen in IDLE at cycle 0, bus_ack in cycle 1, done in cycle 2.
REQ-013 i_stall SHALL equal i_req & ~i_done, and d_stall SHALL equal d_req & ~d_done (combinational).
REQ-014 If a request is deasserted mid-transaction, the bus transaction SHALL still complete, and the done pulse SHALL still be issued.
REQ-015 bus_ack outside BUS SHALL be ignored.
REQ-016 i_rdata and d_rdata SHALL hold their last captured value until the next capture for that requester.
REQ-017 A request held into the RESP cycle SHALL NOT be regranted.
- Regrant SHALL occur only from IDLE.
REQ-018 A new request raised during RESP SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-019 While rst=1, the block SHALL asynchronously force the following:
- state IDLE, last_d 0, counter 0, bus_err 0;
- bus_req, bus_wr, i_done and d_done to 0;
- bus_addr, bus_wdata, bus_wstrb, i_rdata and d_rdata to 0.
REQ-020 Reset asserted in BUS or RESP SHALL abort the transaction without a done pulse.
- After reset release, pending requests SHALL be re-arbitrated, with data first.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- i_req=1, i_addr=0x100, bus_ack in first BUS cycle with bus_rdata=0xDEADBEEF -> bus_req high 1 cycle, bus_wr=0; i_done at cycle 2 with i_rdata=0xDEADBEEF; i_stall high cycles 0-1, low cycle 2.
- i_req and d_req held continuously from reset, d_wr=1, d_addr=0x200, d_wdata=0x12345678, d_wstrb=0xF -> grant order D,I,D,I; first bus_addr=0x200 with bus_wdata=0x12345678.
- d_req read, bus_ack withheld -> RESP after 255 BUS cycles; d_done with d_rdata=0; bus_err=1 and stays 1 through later transactions.
- d_req dropped in the 2nd BUS cycle, ack in the 4th -> d_done still pulses once; no second grant.
- rst pulsed during BUS with i_req and d_req held -> bus_req 0 immediately, no done; after release the first grant is data.
- bus_ack pulsed while in IDLE with no request -> no state change, no done, rdata unchanged.
